// File: rtl/slowclk_pkg.sv
// Shared definitions for the slow-clock divider chain sequencer.
// FSM state encodings, default digit width and the largest BCD digit value.
package slowclk_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_LOAD  = 3'd2,
      S_RUN   = 3'd3,
      S_PAUSE = 3'd4
   } state_t;

   localparam int          DIGIT_W_DFLT = 4;
   localparam logic [3:0]  BCD_MAX      = 4'd9;

endpackage

// File: rtl/slowclk_ent_chain.sv
// Count-enable cascade for the decade stages.
// Stage 0 counts whenever the chain runs; each higher stage counts only
// while every lower stage is at its ripple-carry point. The full chain is
// at terminal count when every stage reports ripple-carry during RUN.
module slowclk_ent_chain
   import slowclk_pkg::*;
#(
   parameter int NUM_STAGES = 2
)(
   input  logic                  run,
   input  logic [NUM_STAGES-1:0] rco_in,
   output logic [NUM_STAGES-1:0] ent,
   output logic                  terminal
);

   // ent cascade and terminal detect, purely combinational
   always_comb begin
      ent      = {NUM_STAGES{1'b0}};
      ent[0]   = run;
      for (int i = 1; i < NUM_STAGES; i++) begin
         ent[i] = run & rco_in[i-1];
      end
      terminal = run & (&rco_in);
   end

endmodule

// File: rtl/slowclk_chain_ctrl.sv
// Sequencer for a cascade of decade counter stages forming the slow-clock divider.
// Converts start/stop/preset commands into stage clear/load/enable strobes,
// chains ent through each stage's rco and flags full-chain terminal count.
// Optional feature macro: SLOWCLK_TICK_CNT_EN adds a wrapping tick_count output.
module slowclk_chain_ctrl
   import slowclk_pkg::*;
#(
   parameter int NUM_STAGES  = 2,
   parameter int DIGIT_W     = DIGIT_W_DFLT,
   parameter int AUTO_RELOAD = 1
`ifdef SLOWCLK_TICK_CNT_EN
   ,parameter int TICK_CNT_W = 8
`endif
)(
   input  logic                          clk,
   input  logic                          clrn,
   input  logic                          start,
   input  logic                          stop,
   input  logic                          preset_req,
   input  logic [NUM_STAGES*DIGIT_W-1:0] preset_val,
   input  logic [NUM_STAGES-1:0]         rco_in,
   output logic                          cnt_clrn,
   output logic                          cnt_ldn,
   output logic                          cnt_enp,
   output logic [NUM_STAGES-1:0]         cnt_ent,
   output logic [NUM_STAGES*DIGIT_W-1:0] cnt_din,
   output logic                          tick,
   output logic                          busy,
`ifdef SLOWCLK_TICK_CNT_EN
   output logic [TICK_CNT_W-1:0]         tick_count,
`endif
   output logic [2:0]                    state_o
);

   state_t                          state_r;
   state_t                          next_state_s;
   state_t                          ret_r;
   state_t                          ret_next_s;
   logic [NUM_STAGES*DIGIT_W-1:0]   preset_r;
   logic                            tick_r;
   logic                            busy_r;
   logic                            run_s;
   logic                            terminal_s;
   logic [NUM_STAGES-1:0]           ent_s;

   assign run_s = (state_r == S_RUN);

   slowclk_ent_chain #(
      .NUM_STAGES (NUM_STAGES)
   ) u_ent_chain (
      .run      (run_s),
      .rco_in   (rco_in),
      .ent      (ent_s),
      .terminal (terminal_s)
   );

   // Stage strobes are decoded straight from the state register so the
   // counters see them in the same cycle; with auto-reload the terminal
   // cycle also pulls ldn low so the stages reload instead of wrapping.
   assign cnt_clrn = ~(state_r == S_CLEAR);
   assign cnt_ldn  = ~((state_r == S_LOAD) | ((AUTO_RELOAD != 0) & terminal_s));
   assign cnt_enp  = run_s;
   assign cnt_ent  = ent_s;
   assign cnt_din  = preset_r;
   assign tick     = tick_r;
   assign busy     = busy_r;
   assign state_o  = state_r;

   // Next-state decode; command priority is stop > preset_req > start
   always_comb begin
      next_state_s = state_r;
      ret_next_s   = ret_r;
      case (state_r)
         S_IDLE: begin
            if (stop) begin
               next_state_s = S_IDLE;
            end else if (preset_req) begin
               next_state_s = S_LOAD;
               ret_next_s   = S_IDLE;
            end else if (start) begin
               next_state_s = S_CLEAR;
            end else begin
               next_state_s = S_IDLE;
            end
         end
         S_CLEAR: begin
            next_state_s = S_RUN;
         end
         S_RUN: begin
            if (stop) begin
               next_state_s = S_PAUSE;
            end else if (preset_req) begin
               next_state_s = S_LOAD;
               ret_next_s   = S_RUN;
            end else begin
               next_state_s = S_RUN;
            end
         end
         S_PAUSE: begin
            if (stop) begin
               next_state_s = S_IDLE;
            end else if (preset_req) begin
               next_state_s = S_LOAD;
               ret_next_s   = S_PAUSE;
            end else if (start) begin
               next_state_s = S_RUN;
            end else begin
               next_state_s = S_PAUSE;
            end
         end
         S_LOAD: begin
            next_state_s = ret_r;
         end
         default: begin
            next_state_s = S_IDLE;
            ret_next_s   = S_IDLE;
         end
      endcase
   end

   // State, return state, captured preset, tick and busy registers
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_r  <= S_IDLE;
         ret_r    <= S_IDLE;
         preset_r <= {(NUM_STAGES*DIGIT_W){1'b0}};
         tick_r   <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         state_r <= next_state_s;
         ret_r   <= ret_next_s;
         if (next_state_s == S_LOAD) begin
            preset_r <= preset_val;
         end else begin
            preset_r <= preset_r;
         end
         tick_r  <= terminal_s;
         busy_r  <= (next_state_s != S_IDLE);
      end
   end

`ifdef SLOWCLK_TICK_CNT_EN
   logic [TICK_CNT_W-1:0] tick_count_r;

   assign tick_count = tick_count_r;

   // Tick counter: cleared by CLEAR, advances once per emitted tick, wraps naturally
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         tick_count_r <= {TICK_CNT_W{1'b0}};
      end else if (state_r == S_CLEAR) begin
         tick_count_r <= {TICK_CNT_W{1'b0}};
      end else if (tick_r) begin
         tick_count_r <= tick_count_r + {{(TICK_CNT_W-1){1'b0}}, 1'b1};
      end else begin
         tick_count_r <= tick_count_r;
      end
   end
`endif

endmodule

// File: tb/tb_slowclk_chain_ctrl.sv
// Bench for slowclk_chain_ctrl: two instances (auto-reload on and off) each
// driving a two-digit behavioural decade counter, checked against directed
// vectors with hand-computed expected values.
module tb_slowclk_chain_ctrl;
   import slowclk_pkg::*;

   logic       clk = 1'b0;
   logic       clrn = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       preset_req = 1'b0;
   logic [7:0] preset_val = 8'h00;

   // auto-reload instance (m) and wrap instance (a)
   logic       clrn_m, ldn_m, enp_m, tick_m, busy_m;
   logic [1:0] ent_m, rco_m;
   logic [7:0] din_m;
   logic [2:0] st_m;
   logic       clrn_a, ldn_a, enp_a, tick_a, busy_a;
   logic [1:0] ent_a, rco_a;
   logic [7:0] din_a;
   logic [2:0] st_a;
`ifdef SLOWCLK_TICK_CNT_EN
   logic [7:0] tc_m, tc_a;
`endif

   logic [3:0] qm0 = 4'd0, qm1 = 4'd0, qa0 = 4'd0, qa1 = 4'd0;

   int total = 0;
   int bad   = 0;

   always #20 clk = ~clk;

   slowclk_chain_ctrl #(.NUM_STAGES(2), .DIGIT_W(4), .AUTO_RELOAD(1)) u_m (
      .clk(clk), .clrn(clrn), .start(start), .stop(stop), .preset_req(preset_req),
      .preset_val(preset_val), .rco_in(rco_m), .cnt_clrn(clrn_m), .cnt_ldn(ldn_m),
      .cnt_enp(enp_m), .cnt_ent(ent_m), .cnt_din(din_m), .tick(tick_m), .busy(busy_m),
`ifdef SLOWCLK_TICK_CNT_EN
      .tick_count(tc_m),
`endif
      .state_o(st_m));

   slowclk_chain_ctrl #(.NUM_STAGES(2), .DIGIT_W(4), .AUTO_RELOAD(0)) u_a (
      .clk(clk), .clrn(clrn), .start(start), .stop(stop), .preset_req(preset_req),
      .preset_val(preset_val), .rco_in(rco_a), .cnt_clrn(clrn_a), .cnt_ldn(ldn_a),
      .cnt_enp(enp_a), .cnt_ent(ent_a), .cnt_din(din_a), .tick(tick_a), .busy(busy_a),
`ifdef SLOWCLK_TICK_CNT_EN
      .tick_count(tc_a),
`endif
      .state_o(st_a));

   // Ripple-carry of a decade stage: counting enabled and all stages up to it at 9
   assign rco_m = {enp_m & (qm0 == BCD_MAX) & (qm1 == BCD_MAX), enp_m & (qm0 == BCD_MAX)};
   assign rco_a = {enp_a & (qa0 == BCD_MAX) & (qa1 == BCD_MAX), enp_a & (qa0 == BCD_MAX)};

   function automatic logic [3:0] inc10(input logic [3:0] d);
      return (d == BCD_MAX) ? 4'd0 : d + 4'd1;
   endfunction

   // Behavioural two-stage decade counter attached to the auto-reload instance
   always @(posedge clk) begin
      if (!clrn_m) begin
         qm0 <= 4'd0; qm1 <= 4'd0;
      end else if (!ldn_m) begin
         qm0 <= din_m[3:0]; qm1 <= din_m[7:4];
      end else begin
         if (enp_m & ent_m[0]) qm0 <= inc10(qm0);
         if (enp_m & ent_m[1]) qm1 <= inc10(qm1);
      end
   end

   // Behavioural two-stage decade counter attached to the wrap instance
   always @(posedge clk) begin
      if (!clrn_a) begin
         qa0 <= 4'd0; qa1 <= 4'd0;
      end else if (!ldn_a) begin
         qa0 <= din_a[3:0]; qa1 <= din_a[7:4];
      end else begin
         if (enp_a & ent_a[0]) qa0 <= inc10(qa0);
         if (enp_a & ent_a[1]) qa1 <= inc10(qa1);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] bcd(input int n);
      logic [3:0] hi, lo;
      hi = 4'(n / 10);
      lo = 4'(n % 10);
      return {hi, lo};
   endfunction

   typedef struct {
      logic       st;
      logic       sp;
      logic       pr;
      logic [2:0] exp_state;
      logic       exp_busy;
      logic       exp_clrn;
      logic       exp_ldn;
      logic       exp_enp;
   } vec_t;

   vec_t tbl[20];

   initial begin
      //            st    sp    pr    state  busy  clrn  ldn   enp
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[5]  = '{1'b0, 1'b1, 1'b1, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[13] = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[15] = '{1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[16] = '{1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[17] = '{1'b0, 1'b1, 1'b1, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[18] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[19] = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0};

      // reset values
      #1;
      chk("rst_state", st_m, 3'd0);
      chk("rst_busy", busy_m, 1'b0);
      chk("rst_tick", tick_m, 1'b0);
      chk("rst_clrn", clrn_m, 1'b1);
      chk("rst_ldn", ldn_m, 1'b1);
      chk("rst_enp", enp_m, 1'b0);
      chk("rst_ent", ent_m, 2'b00);
      chk("rst_din", din_m, 8'h00);
      chk("rst_ldn_a", ldn_a, 1'b1);
      #50;
      @(negedge clk);
      clrn = 1'b1;

      // FSM command table
      for (int i = 0; i < 20; i++) begin
         start = tbl[i].st; stop = tbl[i].sp; preset_req = tbl[i].pr;
         step();
         chk($sformatf("tbl%0d_state", i), st_m, tbl[i].exp_state);
         chk($sformatf("tbl%0d_busy", i), busy_m, tbl[i].exp_busy);
         chk($sformatf("tbl%0d_clrn", i), clrn_m, tbl[i].exp_clrn);
         chk($sformatf("tbl%0d_ldn", i), ldn_m, tbl[i].exp_ldn);
         chk($sformatf("tbl%0d_enp", i), enp_m, tbl[i].exp_enp);
      end
      start = 1'b0; stop = 1'b0; preset_req = 1'b0;

      // reload: load 95 while running, chain reloads every 5 cycles
      start = 1'b1; step(); start = 1'b0;
      step();
      chk("rl_q00", {qm1, qm0}, 8'h00);
      step();
      preset_val = 8'h95; preset_req = 1'b1;
      step();
      preset_req = 1'b0;
      chk("rl_load_state", st_m, 3'd2);
      chk("rl_load_ldn", ldn_m, 1'b0);
      chk("rl_load_din", din_m, 8'h95);
      preset_val = 8'h00;
      step();
      chk("rl_q95", {qm1, qm0}, 8'h95);
      chk("rl_din_held", din_m, 8'h95);
      for (int j = 1; j <= 15; j++) begin
         if (j % 5 == 0) begin
            chk($sformatf("rl_ldn_term%0d", j), ldn_m, 1'b0);
            if (j == 5) chk("wr_ldn_term", ldn_a, 1'b1);
         end
         step();
         chk($sformatf("rl_tick%0d", j), tick_m, (j % 5 == 0) ? 1'b1 : 1'b0);
         chk($sformatf("rl_q%0d", j), {qm1, qm0}, {4'd9, 4'(5 + j % 5)});
         if (j == 5) begin
            chk("wr_q00", {qa1, qa0}, 8'h00);
            chk("wr_tick", tick_a, 1'b1);
         end
         if (j == 6) chk("wr_tick_once", tick_a, 1'b0);
      end

      // pause at 37, resume to 38, held stop walks back to IDLE
      stop = 1'b1; step(); step(); stop = 1'b0;
      chk("ps_idle_busy", busy_m, 1'b0);
      start = 1'b1; step(); start = 1'b0;
      step();
      for (int k = 0; k < 36; k++) step();
      chk("ps_q36", {qm1, qm0}, 8'h36);
      stop = 1'b1; step(); stop = 1'b0;
      chk("ps_state", st_m, 3'd4);
      chk("ps_q37", {qm1, qm0}, 8'h37);
      step();
      chk("ps_hold_q", {qm1, qm0}, 8'h37);
      chk("ps_hold_enp", enp_m, 1'b0);
      chk("ps_hold_ent", ent_m, 2'b00);
      start = 1'b1; step(); start = 1'b0;
      chk("ps_resume_state", st_m, 3'd3);
      chk("ps_resume_q", {qm1, qm0}, 8'h37);
      step();
      chk("ps_q38", {qm1, qm0}, 8'h38);
      stop = 1'b1; step();
      chk("ps_stop1", st_m, 3'd4);
      step(); stop = 1'b0;
      chk("ps_stop2", st_m, 3'd0);
      chk("ps_busy0", busy_m, 1'b0);

      // cascade: 00..99, then reload (m) versus wrap (a)
      start = 1'b1; step(); start = 1'b0;
      step();
      chk("cs_q00", {qm1, qm0}, 8'h00);
      for (int n = 0; n < 99; n++) begin
         chk($sformatf("cs_ent1_%0d", n), ent_m[1], (n % 10 == 9) ? 1'b1 : 1'b0);
         step();
         chk($sformatf("cs_q%0d", n + 1), {qm1, qm0}, bcd(n + 1));
      end
      chk("cs_tick_pre", tick_m, 1'b0);
      chk("cs_ldn_m99", ldn_m, 1'b0);
      chk("cs_ldn_a99", ldn_a, 1'b1);
      step();
      chk("cs_reload_q", {qm1, qm0}, 8'h95);
      chk("cs_wrap_q", {qa1, qa0}, 8'h00);
      chk("cs_tick_m", tick_m, 1'b1);
      chk("cs_tick_a", tick_a, 1'b1);
      step();
      chk("cs_tick_m_off", tick_m, 1'b0);
      chk("cs_tick_a_off", tick_a, 1'b0);

      // reset asserted in the middle of a LOAD cycle
      preset_val = 8'h42; preset_req = 1'b1;
      step(); preset_req = 1'b0;
      chk("rl_mid_ldn", ldn_m, 1'b0);
      #5 clrn = 1'b0;
      #1;
      chk("rm_ldn", ldn_m, 1'b1);
      chk("rm_state", st_m, 3'd0);
      chk("rm_busy", busy_m, 1'b0);
      chk("rm_din", din_m, 8'h00);
      #30 clrn = 1'b1;
      step();
      chk("rm_idle_after", st_m, 3'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
